risc_tlb_cam: RTL and testbench

//  Parametrised fully-associative TLB for the RiSC MMU. Replaces the fixed single-entry

---
 rtl/risc_tlb_cam_if.sv | 39 +++
 rtl/risc_tlb_cam.sv | 145 ++++++++++++++
 tb/tb_risc_tlb_cam.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/risc_tlb_cam_if.sv
// Lookup, refill and flush signals between the RiSC MMU address path and the TLB CAM.
// The master side issues requests; the slave side (the TLB) returns registered results.
interface risc_tlb_cam_if #(
  parameter int unsigned VPN_W  = 8,
  parameter int unsigned PFN_W  = 8,
  parameter int unsigned ASID_W = 6,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned IDX_W  = 3
);
  logic              lk_req;
  logic [VPN_W-1:0]  lk_vpn;
  logic [ASID_W-1:0] lk_asid;
  logic              lk_done;
  logic              lk_hit;
  logic [PFN_W-1:0]  lk_pfn;
  logic              wr_en;
  logic              wr_auto;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_v;
  logic              wr_g;
  logic [VPN_W-1:0]  wr_vpn;
  logic [ASID_W-1:0] wr_asid;
  logic [PFN_W-1:0]  wr_pfn;
  logic              fl_all;
  logic              fl_asid;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    output lk_req, lk_vpn, lk_asid, wr_en, wr_auto, wr_idx, wr_v, wr_g,
           wr_vpn, wr_asid, wr_pfn, fl_all, fl_asid,
    input  lk_done, lk_hit, lk_pfn, miss_cnt
  );

  modport slave (
    input  lk_req, lk_vpn, lk_asid, wr_en, wr_auto, wr_idx, wr_v, wr_g,
           wr_vpn, wr_asid, wr_pfn, fl_all, fl_asid,
    output lk_done, lk_hit, lk_pfn, miss_cnt
  );
endinterface

// File: rtl/risc_tlb_cam.sv
// Fully-associative TLB: registered (ASID,VPN)->PFN lookup, global entries,
// automatic refill-slot choice, ASID/full flush and a saturating miss counter.
module risc_tlb_cam #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned VPN_W   = 8,
  parameter int unsigned PFN_W   = 8,
  parameter int unsigned ASID_W  = 6,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  risc_tlb_cam_if.slave     bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic              v_q    [ENTRIES];
  logic              v_d    [ENTRIES];
  logic              g_q    [ENTRIES];
  logic              g_d    [ENTRIES];
  logic [VPN_W-1:0]  vpn_q  [ENTRIES];
  logic [VPN_W-1:0]  vpn_d  [ENTRIES];
  logic [ASID_W-1:0] asid_q [ENTRIES];
  logic [ASID_W-1:0] asid_d [ENTRIES];
  logic [PFN_W-1:0]  pfn_q  [ENTRIES];
  logic [PFN_W-1:0]  pfn_d  [ENTRIES];

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              lk_done_q, lk_done_d;
  logic              lk_hit_q, lk_hit_d;
  logic [PFN_W-1:0]  lk_pfn_q, lk_pfn_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic              hit_c;
  logic [PFN_W-1:0]  hit_pfn_c;
  logic              dup_found_c, free_found_c;
  logic [IDX_W-1:0]  dup_idx_c, free_idx_c, wr_slot_c;

  // Lookup against pre-edge contents; descending scan so the lowest match wins
  always_comb begin
    hit_c     = 1'b0;
    hit_pfn_c = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (v_q[i] && vpn_q[i] == bus.lk_vpn && (g_q[i] || asid_q[i] == bus.lk_asid)) begin
        hit_c     = 1'b1;
        hit_pfn_c = pfn_q[i];
      end
    end
  end

  always_comb begin
    lk_done_d  = 1'b0;
    lk_hit_d   = lk_hit_q;
    lk_pfn_d   = lk_pfn_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.lk_req) begin
      lk_done_d = 1'b1;
      lk_hit_d  = hit_c;
      lk_pfn_d  = hit_c ? hit_pfn_c : '0;
      if (!hit_c && miss_cnt_q != {CNT_W{1'b1}}) begin
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // Flush first, then pick the refill slot from post-flush validity and write it
  always_comb begin
    v_d          = v_q;
    g_d          = g_q;
    vpn_d        = vpn_q;
    asid_d       = asid_q;
    pfn_d        = pfn_q;
    rr_ptr_d     = rr_ptr_q;
    dup_found_c  = 1'b0;
    dup_idx_c    = '0;
    free_found_c = 1'b0;
    free_idx_c   = '0;
    wr_slot_c    = bus.wr_idx;

    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (bus.fl_all || (bus.fl_asid && !g_q[i] && asid_q[i] == bus.lk_asid)) begin
        v_d[i] = 1'b0;
      end
    end

    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (v_d[i] && vpn_q[i] == bus.wr_vpn && (g_q[i] || asid_q[i] == bus.wr_asid)) begin
        dup_found_c = 1'b1;
        dup_idx_c   = IDX_W'(i);
      end
      if (!v_d[i]) begin
        free_found_c = 1'b1;
        free_idx_c   = IDX_W'(i);
      end
    end

    if (bus.wr_en) begin
      if (bus.wr_auto) begin
        if (dup_found_c) begin
          wr_slot_c = dup_idx_c;
        end else if (free_found_c) begin
          wr_slot_c = free_idx_c;
        end else begin
          wr_slot_c = rr_ptr_q;
          rr_ptr_d  = rr_ptr_q + IDX_W'(1);
        end
      end
      v_d[wr_slot_c]    = bus.wr_v;
      g_d[wr_slot_c]    = bus.wr_g;
      vpn_d[wr_slot_c]  = bus.wr_vpn;
      asid_d[wr_slot_c] = bus.wr_asid;
      pfn_d[wr_slot_c]  = bus.wr_pfn;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q        <= '{default: '0};
      g_q        <= '{default: '0};
      vpn_q      <= '{default: '0};
      asid_q     <= '{default: '0};
      pfn_q      <= '{default: '0};
      rr_ptr_q   <= '0;
      lk_done_q  <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_pfn_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      v_q        <= v_d;
      g_q        <= g_d;
      vpn_q      <= vpn_d;
      asid_q     <= asid_d;
      pfn_q      <= pfn_d;
      rr_ptr_q   <= rr_ptr_d;
      lk_done_q  <= lk_done_d;
      lk_hit_q   <= lk_hit_d;
      lk_pfn_q   <= lk_pfn_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.lk_done  = lk_done_q;
  assign bus.lk_hit   = lk_hit_q;
  assign bus.lk_pfn   = lk_pfn_q;
  assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_risc_tlb_cam.sv
// Directed bench for risc_tlb_cam: stimulus pushes expected lookup results into a
// queue, a negedge monitor pops and compares each time lk_done is presented.
module tb_risc_tlb_cam;
  localparam int unsigned ENTRIES = 8;
  localparam int unsigned VPN_W   = 8;
  localparam int unsigned PFN_W   = 8;
  localparam int unsigned ASID_W  = 6;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 3;

  typedef struct {
    logic             hit;
    logic [PFN_W-1:0] pfn;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  logic [CNT_W-1:0] ecnt;
  int n_checks;
  int n_fail;

  risc_tlb_cam_if #(.VPN_W(VPN_W), .PFN_W(PFN_W), .ASID_W(ASID_W),
                    .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  risc_tlb_cam #(.ENTRIES(ENTRIES), .VPN_W(VPN_W), .PFN_W(PFN_W),
                 .ASID_W(ASID_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every presented result must match the oldest expectation
  always @(negedge clk) begin
    if (bus.lk_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_lk_done: got lk_done=1 expected no result at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("lk_hit", 32'(bus.lk_hit), 32'(e.hit));
        chk("lk_pfn", 32'(bus.lk_pfn), 32'(e.pfn));
        chk("miss_cnt", 32'(bus.miss_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.lk_req  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.fl_all  = 1'b0;
    bus.fl_asid = 1'b0;
  endtask

  task automatic set_lk(input logic [7:0] vpn, input logic [5:0] asid,
                        input logic hit, input logic [7:0] pfn);
    exp_t e;
    bus.lk_req  = 1'b1;
    bus.lk_vpn  = vpn;
    bus.lk_asid = asid;
    if (!hit && ecnt != 4'hF) ecnt = ecnt + 4'd1;
    e.hit = hit;
    e.pfn = hit ? pfn : 8'h00;
    e.cnt = ecnt;
    sb_q.push_back(e);
  endtask

  task automatic set_wr(input logic au, input logic [2:0] idx, input logic v, input logic g,
                        input logic [7:0] vpn, input logic [5:0] asid, input logic [7:0] pfn);
    bus.wr_en   = 1'b1;
    bus.wr_auto = au;
    bus.wr_idx  = idx;
    bus.wr_v    = v;
    bus.wr_g    = g;
    bus.wr_vpn  = vpn;
    bus.wr_asid = asid;
    bus.wr_pfn  = pfn;
  endtask

  task automatic lookup(input logic [7:0] vpn, input logic [5:0] asid,
                        input logic hit, input logic [7:0] pfn);
    set_lk(vpn, asid, hit, pfn);
    cyc();
    clear_req();
  endtask

  task automatic wr_auto(input logic g, input logic [7:0] vpn, input logic [5:0] asid,
                         input logic [7:0] pfn);
    set_wr(1'b1, 3'd0, 1'b1, g, vpn, asid, pfn);
    cyc();
    clear_req();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ecnt     = '0;
    reset    = 1'b0;
    clear_req();
    bus.lk_vpn = '0; bus.lk_asid = '0;
    bus.wr_auto = 1'b0; bus.wr_idx = '0; bus.wr_v = 1'b0; bus.wr_g = 1'b0;
    bus.wr_vpn = '0; bus.wr_asid = '0; bus.wr_pfn = '0;
    repeat (3) cyc();
    chk("reset_lk_done", 32'(bus.lk_done), 32'd0);
    chk("reset_lk_hit", 32'(bus.lk_hit), 32'd0);
    chk("reset_lk_pfn", 32'(bus.lk_pfn), 32'd0);
    chk("reset_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    reset = 1'b1;
    cyc();

    // First lookup after reset misses
    lookup(8'h00, 6'd9, 1'b0, 8'h00);
    // Single entry, ASID sensitivity
    wr_auto(1'b0, 8'h00, 6'd9, 8'h03);
    lookup(8'h00, 6'd9, 1'b1, 8'h03);
    lookup(8'h00, 6'd8, 1'b0, 8'h00);
    // Global entry survives an ASID flush
    wr_auto(1'b1, 8'h10, 6'd5, 8'h7F);
    lookup(8'h10, 6'd1, 1'b1, 8'h7F);
    lookup(8'h10, 6'd9, 1'b1, 8'h7F);
    bus.fl_asid = 1'b1; bus.lk_asid = 6'd9;
    cyc();
    clear_req();
    lookup(8'h10, 6'd9, 1'b1, 8'h7F);
    lookup(8'h00, 6'd9, 1'b0, 8'h00);

    // Fill all slots, then round-robin replacement of slots 0,1,2
    bus.fl_all = 1'b1;
    cyc();
    clear_req();
    for (int i = 0; i < 8; i++) wr_auto(1'b0, 8'(8'h20 + i), 6'd9, 8'(8'h40 + i));
    lookup(8'h20, 6'd9, 1'b1, 8'h40);
    wr_auto(1'b0, 8'h30, 6'd9, 8'h50);
    wr_auto(1'b0, 8'h31, 6'd9, 8'h51);
    wr_auto(1'b0, 8'h32, 6'd9, 8'h52);
    lookup(8'h20, 6'd9, 1'b0, 8'h00);
    lookup(8'h22, 6'd9, 1'b0, 8'h00);
    lookup(8'h23, 6'd9, 1'b1, 8'h43);
    lookup(8'h30, 6'd9, 1'b1, 8'h50);
    lookup(8'h32, 6'd9, 1'b1, 8'h52);
    // Rewriting an existing translation reuses its slot and leaves rr_ptr at 3
    wr_auto(1'b0, 8'h25, 6'd9, 8'h65);
    lookup(8'h25, 6'd9, 1'b1, 8'h65);
    wr_auto(1'b0, 8'h33, 6'd9, 8'h53);
    lookup(8'h23, 6'd9, 1'b0, 8'h00);
    lookup(8'h24, 6'd9, 1'b1, 8'h44);
    lookup(8'h33, 6'd9, 1'b1, 8'h53);
    // Explicit index write does not move rr_ptr (still 4)
    set_wr(1'b0, 3'd6, 1'b1, 1'b0, 8'h40, 6'd9, 8'h66);
    cyc();
    clear_req();
    lookup(8'h26, 6'd9, 1'b0, 8'h00);
    lookup(8'h40, 6'd9, 1'b1, 8'h66);
    wr_auto(1'b0, 8'h34, 6'd9, 8'h54);
    lookup(8'h24, 6'd9, 1'b0, 8'h00);
    lookup(8'h34, 6'd9, 1'b1, 8'h54);
    // Duplicate entries: lowest index wins
    set_wr(1'b0, 3'd7, 1'b1, 1'b0, 8'h40, 6'd9, 8'h77);
    cyc();
    clear_req();
    lookup(8'h40, 6'd9, 1'b1, 8'h66);

    // Same-cycle lookup and overwrite: old value first, new value after
    set_lk(8'h30, 6'd9, 1'b1, 8'h50);
    set_wr(1'b1, 3'd0, 1'b1, 1'b0, 8'h30, 6'd9, 8'h5A);
    cyc();
    clear_req();
    lookup(8'h30, 6'd9, 1'b1, 8'h5A);
    // Same-cycle full flush and write: only the written entry remains
    bus.fl_all = 1'b1;
    set_wr(1'b1, 3'd0, 1'b1, 1'b0, 8'h70, 6'd9, 8'h11);
    cyc();
    clear_req();
    lookup(8'h70, 6'd9, 1'b1, 8'h11);
    lookup(8'h10, 6'd9, 1'b0, 8'h00);
    lookup(8'h30, 6'd9, 1'b0, 8'h00);
    lookup(8'h40, 6'd9, 1'b0, 8'h00);

    // Miss counter climbs to all-ones and holds
    for (int i = 0; i < 6; i++) lookup(8'hE0, 6'd3, 1'b0, 8'h00);
    drain();
    chk("miss_cnt_saturated", 32'(bus.miss_cnt), 32'hF);

    // Reset during an outstanding lookup drops it
    bus.lk_req = 1'b1; bus.lk_vpn = 8'h70; bus.lk_asid = 6'd9;
    #2;
    reset = 1'b0;
    ecnt  = '0;
    cyc();
    clear_req();
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    chk("post_reset_lk_done", 32'(bus.lk_done), 32'd0);
    chk("post_reset_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    lookup(8'h70, 6'd9, 1'b0, 8'h00);
    lookup(8'h10, 6'd9, 1'b0, 8'h00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
